// File: rtl/dual_port_ram_pkg.sv
// Shared types and constants for the byte-enabled true dual-port RAM.
//   rdw_mode_e  : same-port read-during-write behaviour selector
//   clr_state_e : states of the array clear engine
//   BYTE_W      : width of one byte lane
package dual_port_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/dual_port_ram_clear_fsm.sv
// Clear engine for dual_port_ram_be. On a one-cycle clear request it walks
// every address once, writing zero, and steals port A's write path while
// doing so.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             clear request (ignored while busy)
//   busy              high for exactly 2**ADDR_WIDTH cycles per clear
//   a_wr, a_be,
//   a_addr, a_din     port A write request (already qualified by the top)
//   wa_be, wa_addr,
//   wa_din            write path into the array for port A
module dual_port_ram_clear_fsm
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NB         = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  a_wr,
  input  logic [NB-1:0]         a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [NB-1:0]         wa_be,
  output logic [ADDR_WIDTH-1:0] wa_addr,
  output logic [DATA_WIDTH-1:0] wa_din
);

  clr_state_e            state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic                  clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        // Counter wraps back to zero on the last address.
        cnt_nx = cnt + 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);

  // A reset cycle in the middle of a clear must not write anything.
  assign clr_we = busy && !rst;

  assign wa_be   = clr_we ? {NB{1'b1}} : (a_wr ? a_be : {NB{1'b0}});
  assign wa_addr = clr_we ? cnt : a_addr;
  assign wa_din  = clr_we ? {DATA_WIDTH{1'b0}} : a_din;

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM, one clock, per-byte write enables, selectable
// same-port read-during-write behaviour and a built-in zero-fill engine.
// Optional macro DUAL_PORT_RAM_OUT_REG_EN adds an output register stage
// (read latency 2 instead of 1).
// Ports (X = a, b):
//   clk, rst      clock, synchronous active-high reset
//   clear, busy   zero-fill request / engine running (ports ignored)
//   X_en, X_we    access enable, write select
//   X_be          byte lane write enables
//   X_addr, X_din word address, write data
//   X_dout        read data (holds between accesses)
//   X_valid       one-cycle pulse when X_dout carries a new result
module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RDW_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  output logic                         busy,
  input  logic                         a_en,
  input  logic                         a_we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [DATA_WIDTH-1:0]        a_din,
  output logic [DATA_WIDTH-1:0]        a_dout,
  output logic                         a_valid,
  input  logic                         b_en,
  input  logic                         b_we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic [DATA_WIDTH-1:0]        b_din,
  output logic [DATA_WIDTH-1:0]        b_dout,
  output logic                         b_valid
);

  localparam int        NB    = DATA_WIDTH / BYTE_W;
  localparam int        DEPTH = 1 << ADDR_WIDTH;
  localparam rdw_mode_e RDW   = rdw_mode_e'(RDW_MODE[1:0]);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_acc, b_acc, a_wr, b_wr;
  logic [NB-1:0]         wa_be, wb_be;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_din;
  logic [DATA_WIDTH-1:0] a_dout_p0, b_dout_p0;
  logic                  a_vld_p0, b_vld_p0;

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    return r;
  endfunction

  // A write with no lanes enabled behaves as a read.
  assign a_acc = a_en && !busy && !rst;
  assign b_acc = b_en && !busy && !rst;
  assign a_wr  = a_acc && a_we && (|a_be);
  assign b_wr  = b_acc && b_we && (|b_be);
  assign wb_be = b_wr ? b_be : {NB{1'b0}};

  dual_port_ram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NB         (NB)
  ) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .busy    (busy),
    .a_wr    (a_wr),
    .a_be    (a_be),
    .a_addr  (a_addr),
    .a_din   (a_din),
    .wa_be   (wa_be),
    .wa_addr (wa_addr),
    .wa_din  (wa_din)
  );

  // Port A is applied after port B so it wins lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wb_be[i]) mem[b_addr][i*BYTE_W +: BYTE_W] <= b_din[i*BYTE_W +: BYTE_W];
      if (wa_be[i]) mem[wa_addr][i*BYTE_W +: BYTE_W] <= wa_din[i*BYTE_W +: BYTE_W];
    end
  end

  // ---- stage p0: array read register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout_p0 <= '0;
      a_vld_p0  <= 1'b0;
    end else begin
      a_vld_p0 <= 1'b0;
      if (a_acc) begin
        if (!a_wr) begin
          a_dout_p0 <= mem[a_addr];
          a_vld_p0  <= 1'b1;
        end else begin
          case (RDW)
            WRITE_FIRST: begin
              a_dout_p0 <= lane_merge(mem[a_addr], a_din, a_be);
              a_vld_p0  <= 1'b1;
            end
            NO_CHANGE: ;
            default: begin
              a_dout_p0 <= mem[a_addr];
              a_vld_p0  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_dout_p0 <= '0;
      b_vld_p0  <= 1'b0;
    end else begin
      b_vld_p0 <= 1'b0;
      if (b_acc) begin
        if (!b_wr) begin
          b_dout_p0 <= mem[b_addr];
          b_vld_p0  <= 1'b1;
        end else begin
          case (RDW)
            WRITE_FIRST: begin
              b_dout_p0 <= lane_merge(mem[b_addr], b_din, b_be);
              b_vld_p0  <= 1'b1;
            end
            NO_CHANGE: ;
            default: begin
              b_dout_p0 <= mem[b_addr];
              b_vld_p0  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

`ifdef DUAL_PORT_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] a_dout_p1, b_dout_p1;
  logic                  a_vld_p1, b_vld_p1;

  // ---- stage p1: optional output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout_p1 <= '0;
      b_dout_p1 <= '0;
      a_vld_p1  <= 1'b0;
      b_vld_p1  <= 1'b0;
    end else begin
      a_dout_p1 <= a_dout_p0;
      b_dout_p1 <= b_dout_p0;
      a_vld_p1  <= a_vld_p0;
      b_vld_p1  <= b_vld_p0;
    end
  end

  assign a_dout  = a_dout_p1;
  assign b_dout  = b_dout_p1;
  assign a_valid = a_vld_p1;
  assign b_valid = b_vld_p1;
`else
  assign a_dout  = a_dout_p0;
  assign b_dout  = b_dout_p0;
  assign a_valid = a_vld_p0;
  assign b_valid = b_vld_p0;
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
module tb_dual_port_ram_be;

  parameter int RDW = 0;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef DUAL_PORT_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, clear, busy;
  logic          a_en, a_we, b_en, b_we, a_valid, b_valid;
  logic [3:0]    a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din, a_dout, b_dout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left = 0;
  logic [DW-1:0] ma_d1 = '0, mb_d1 = '0, ma_d2 = '0, mb_d2 = '0;
  logic          ma_v1 = 1'b0, mb_v1 = 1'b0, ma_v2 = 1'b0, mb_v2 = 1'b0;

  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(RDW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_valid(b_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Result of one accepted access on a port, following the RDW rules.
  task automatic port_result(input logic en, input logic we, input logic [3:0] be,
                             input logic [DW-1:0] din, input logic [DW-1:0] old,
                             inout logic [DW-1:0] d, output logic v);
    v = 1'b0;
    if (en) begin
      if (!(we && be != 4'h0)) begin d = old; v = 1'b1; end
      else if (RDW == 0) begin d = old; v = 1'b1; end
      else if (RDW == 1) begin d = merge(old, din, be); v = 1'b1; end
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] old_a, old_b;
    if (rst) begin
      clr_left = 0;
      ma_d1 = '0; mb_d1 = '0; ma_d2 = '0; mb_d2 = '0;
      ma_v1 = 0;  mb_v1 = 0;  ma_v2 = 0;  mb_v2 = 0;
      return;
    end
    ma_d2 = ma_d1; mb_d2 = mb_d1; ma_v2 = ma_v1; mb_v2 = mb_v1;
    if (clr_left > 0) begin
      mem_m[DEPTH - clr_left] = '0;
      clr_left--;
      ma_v1 = 1'b0;
      mb_v1 = 1'b0;
    end else begin
      old_a = mem_m[a_addr];
      old_b = mem_m[b_addr];
      port_result(a_en, a_we, a_be, a_din, old_a, ma_d1, ma_v1);
      port_result(b_en, b_we, b_be, b_din, old_b, mb_d1, mb_v1);
      // Port A takes priority on lanes written by both ports.
      if (b_en && b_we) mem_m[b_addr] = merge(mem_m[b_addr], b_din, b_be);
      if (a_en && a_we) mem_m[a_addr] = merge(mem_m[a_addr], a_din, a_be);
      if (clear) clr_left = DEPTH;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("a_dout",  a_dout,  (LAT == 2) ? ma_d2 : ma_d1);
    chk("a_valid", {31'b0, a_valid}, {31'b0, (LAT == 2) ? ma_v2 : ma_v1});
    chk("b_dout",  b_dout,  (LAT == 2) ? mb_d2 : mb_d1);
    chk("b_valid", {31'b0, b_valid}, {31'b0, (LAT == 2) ? mb_v2 : mb_v1});
    chk("busy",    {31'b0, busy}, (clr_left > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    a_en = en; a_we = we; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    b_en = en; b_we = we; b_be = be; b_addr = addr; b_din = din;
  endtask

  task automatic idle();
    set_a(0, 0, 4'h0, '0, '0);
    set_b(0, 0, 4'h0, '0, '0);
    clear = 1'b0;
  endtask

  task automatic rnd_ports();
    set_a(1'($urandom), 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
    set_b(1'($urandom), 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
  endtask

  task automatic drain();
    idle();
    repeat (LAT - 1) tick();
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1;
    idle();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Clear with random (ignored) traffic and clear requests while busy
    clear = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      rnd_ports();
      clear = 1'($urandom);
      if (i >= DEPTH - 1) clear = 1'b0;
      if (i >= DEPTH) idle();
      tick();
      if (busy) busy_cnt++;
    end
    idle();
    chk("busy_len", busy_cnt, DEPTH - 1);

    // Basic write on A, read on B
    set_a(1, 1, 4'hF, 5, 32'hDEADBEEF); tick(); idle();
    set_b(1, 0, 4'h0, 5, '0); tick(); drain();
    chk("rd_b5", b_dout, 32'hDEADBEEF);
    chk("rd_b5_vld", {31'b0, b_valid}, 32'd1);

    // Byte enables
    set_a(1, 1, 4'hF, 7, 32'h11223344); tick();
    set_a(1, 1, 4'b0101, 7, 32'hAABBCCDD); tick();
    set_a(1, 0, 4'h0, 7, '0); tick(); drain();
    chk("be_merge", a_dout, 32'h11BB33DD);

    // Same-port read-during-write
    set_a(1, 1, 4'hF, 3, 32'h1); tick();
    set_a(1, 0, 4'h0, 3, '0); tick();
    set_a(1, 1, 4'hF, 3, 32'h2); tick(); drain();
    chk("rdw_dout", a_dout, (RDW == 1) ? 32'h2 : 32'h1);
    chk("rdw_vld", {31'b0, a_valid}, (RDW == 2) ? 32'd0 : 32'd1);
    set_a(1, 0, 4'h0, 3, '0); tick(); drain();
    chk("rdw_after", a_dout, 32'h2);

    // Cross-port collisions at address 9
    set_a(1, 1, 4'hF, 9, 32'hFFFF0000);
    set_b(1, 1, 4'h3, 9, 32'h0000FFFF); tick();
    set_a(1, 1, 4'hF, 9, 32'h12345678);
    set_b(1, 0, 4'h0, 9, '0); tick(); drain();
    chk("coll_b_old", b_dout, 32'hFFFF0000);
    set_b(1, 0, 4'h0, 9, '0); tick(); drain();
    chk("coll_new", b_dout, 32'h12345678);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      rnd_ports();
      clear = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle();
    repeat (DEPTH + 2) tick();

    // Reset in the middle of a clear
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_adout", a_dout, 32'd0);
    chk("abort_bvld", {31'b0, b_valid}, 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (DEPTH) tick();
    chk("reclear_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1, 0, 4'h0, AW'(i), '0);
      set_b(1, 0, 4'h0, AW'(DEPTH - 1 - i), '0);
      tick();
    end
    drain();
    chk("zero_last", b_dout, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Parametrised true dual-port block RAM: two independent read/write ports on one clock, per-byte write enables, selectable read-during-write behaviour, and a built-in clear engine that zero-fills the array on request. It is the general-purpose on-chip storage primitive for buffers and tables that need concurrent access. Designed to infer BRAM on FPGA.

## Interface
- ADDR_WIDTH, 10: address bits per port; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32: word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
- RDW_MODE, 0: same-port read-during-write; 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE

Ports (X = a or b; both ports identical):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  one-cycle request to zero the whole array
- busy  out  1  high while the clear engine runs
- X_en  in  1  port access enable
- X_we  in  1  write (with X_en)
- X_be  in  NB  byte write enables; lane i covers bits [8i+7:8i]
- X_addr  in  ADDR_WIDTH  word address
- X_din  in  DATA_WIDTH  write data
- X_dout  out  DATA_WIDTH  read data
- X_valid  out  1  X_dout carries data for an access issued LAT cycles earlier

## Operation
- Access: X_en=1, X_we=0 reads mem[X_addr]. X_en=1, X_we=1 writes the lanes set in X_be. A write with X_be=0 is a read for RDW purposes.
- Same-port read-during-write:
  - READ_FIRST: X_dout = old word.
  - WRITE_FIRST: X_dout = merged new word (written lanes new, others old).
  - NO_CHANGE: X_dout holds; X_valid stays 0 for that access.
- Cross-port, same address, same cycle:
  - One port writes, other reads: reader gets old word.
  - Both write: lanes enabled on both take a_din; other lanes take whichever port enabled them.
- Clear engine FSM with states IDLE and CLEAR:
  - IDLE -> CLEAR on clear=1; internal counter loads 0 and busy=1 from the next cycle.
  - CLEAR writes 0 to mem[counter] each cycle and increments the counter; returns to IDLE after address 2**ADDR_WIDTH-1.
  - CLEAR lasts exactly 2**ADDR_WIDTH cycles. clear asserted while busy is ignored.
  - While busy, both ports are ignored (no writes, X_valid=0).
- Reset:
  - All X_dout=0, X_valid=0, busy=0, FSM to IDLE, counter=0.
  - Array contents are not reset. rst during CLEAR aborts it; array contents are then undefined.
  - rst has priority over clear and port accesses in the same cycle.

## Timing
- LAT = 1 without OUT_REG_EN, 2 with it. Access at edge n gives X_dout/X_valid valid after edge n+LAT-1+1, i.e. visible in cycle n+LAT.
- X_valid is a single-cycle pulse per accepted read or RDW access; X_dout holds its value between accesses.
- Ports are fully pipelined: one access per port per cycle, no backpressure.
- busy rises in the cycle after clear is sampled. It falls in the cycle after the last zero write; ports are usable in that cycle.

## Configuration
- DUAL_PORT_RAM_OUT_REG_EN defined: adds an extra output register stage on X_dout/X_valid per port, LAT=2. The register resets to 0. Use for timing closure with BRAM output registers.
- Undefined: LAT=1, array read register drives X_dout directly.

## Structure
- Package dual_port_ram_pkg:
  - rdw_mode_e enum (READ_FIRST, WRITE_FIRST, NO_CHANGE)
  - clr_state_e enum (IDLE, CLEAR)
  - localparam BYTE_W = 8
- Sub-module dual_port_ram_clear_fsm: FSM, counter, busy, and the zero-write address/enable muxed onto port A's write path.
- Array, port logic, and the optional output stage stay in the top module.

## Test plan
- Reset then write a: addr 5, din 0xDEADBEEF, be 4'hF; read b addr 5 -> b_dout=0xDEADBEEF, b_valid pulses exactly LAT cycles after the read.
- Byte enables: word 0x11223344 at addr 7, then write 0xAABBCCDD with be 4'b0101 -> readback 0x11BB33DD.
- RDW per mode: addr 3 holds 0x1, write 0x2 on a with read:
  - READ_FIRST: a_dout=0x1
  - WRITE_FIRST: a_dout=0x2
  - NO_CHANGE: a_dout holds and a_valid=0
  - Later read returns 0x2 in all modes.
- Collisions at addr 9:
  - a writes 0xFFFF0000 be 4'hF while b writes 0x0000FFFF be 4'h3 -> mem=0xFFFF0000.
  - a writes while b reads -> b gets old data.
- Clear with ADDR_WIDTH=4: fill all 16 words, pulse clear -> busy high 16 cycles; accesses during busy ignored; all words read 0.
- rst asserted at clear cycle 5: busy=0, all dout/valid=0 next cycle; new clear completes normally.
